// File: rtl/calc_pkg.sv
// Shared types and constants for the placement calculator and its sequencer.
// Tile/rotation widths, FSM state encoding and the calc "no position" code.
package calc_pkg;
  localparam int TILE_W   = 4;
  localparam int ROT_W    = 2;
  localparam int COL_W    = 4;
  localparam int COLS_DEF = 10;

  localparam logic [COL_W-1:0] NO_PROPER_POS = 4'd11;

  typedef logic [TILE_W-1:0] tile_t;
  typedef logic [ROT_W-1:0]  rot_t;
  typedef logic [COL_W-1:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_PRESENT = 2'd2
  } seq_state_e;

  typedef struct packed {
    tile_t block;
    col_t  col;
    rot_t  rot;
    logic  fallback;
  } placement_t;

  // The calc's "no position" code is never a usable column, whatever the board width.
  function automatic logic col_in_range(input col_t col, input int cols);
    return (col != NO_PROPER_POS) && (int'({1'b0, col}) < cols);
  endfunction
endpackage

// File: rtl/calc_sequencer_if.sv
// Bundle of the tile input, calc req/resp and placement output handshakes.
// slave = the sequencer side, master = the surrounding environment.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic       blk_valid;
  tile_t      blk_in;
  logic       blk_ready;

  logic       req_to_client;
  tile_t      cur_block;
  logic       resp_from_client;
  col_t       opt_col;
  rot_t       opt_rotation;

  logic       place_valid;
  tile_t      place_block;
  col_t       place_col;
  rot_t       place_rotation;
  logic       place_fallback;
  logic       place_ready;

  logic       busy;
  logic [7:0] timeout_cnt;

  modport slave (
    input  blk_valid, blk_in, resp_from_client, opt_col, opt_rotation, place_ready,
    output blk_ready, req_to_client, cur_block, place_valid, place_block,
           place_col, place_rotation, place_fallback, busy, timeout_cnt
  );

  modport master (
    output blk_valid, blk_in, resp_from_client, opt_col, opt_rotation, place_ready,
    input  blk_ready, req_to_client, cur_block, place_valid, place_block,
           place_col, place_rotation, place_fallback, busy, timeout_cnt
  );
endinterface

// File: rtl/calc_blk_fifo.sv
// Small synchronous tile FIFO; head is visible on dout while not empty.
// Pushes on full and pops on empty are dropped internally.
module calc_blk_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en;
  logic          pop_en;
  logic [DEPTH-1:0][W-1:0] mem_vec;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_vec[rd_ptr_q];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [W-1:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (push_en && (wr_ptr_q == AW'(gi))) begin
        ent_d = din;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign mem_vec[gi] = ent_q;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/calc_sequencer.sv
// Queues tiles, runs one calc request per tile with a timeout and column range
// guard, and offers the resulting placement on a valid/ready output.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int COLS        = COLS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  calc_sequencer_if.slave bus
);
  localparam int CW     = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  tile_t             cur_block_q, cur_block_d;
  placement_t        place_q, place_d;
  logic              place_valid_q, place_valid_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;

  logic              pop_fire;
  tile_t             fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  calc_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TILE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.blk_valid),
    .pop   (pop_fire),
    .din   (bus.blk_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    req_d         = req_q;
    cur_block_d   = cur_block_q;
    place_d       = place_q;
    place_valid_d = place_valid_q;
    timeout_cnt_d = timeout_cnt_q;
    pop_fire      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A response still high from the previous request must not be taken as the next one.
        if (!fifo_empty && !bus.resp_from_client) begin
          state_d     = ST_ISSUE;
          pop_fire    = 1'b1;
          cur_block_d = fifo_dout;
          req_d       = 1'b1;
          wait_d      = '0;
        end
      end

      ST_ISSUE: begin
        if (bus.resp_from_client) begin
          state_d        = ST_PRESENT;
          req_d          = 1'b0;
          place_valid_d  = 1'b1;
          place_d.block  = cur_block_q;
          if (col_in_range(bus.opt_col, COLS)) begin
            place_d.col      = bus.opt_col;
            place_d.rot      = bus.opt_rotation;
            place_d.fallback = 1'b0;
          end else begin
            place_d.col      = '0;
            place_d.rot      = '0;
            place_d.fallback = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d          = ST_PRESENT;
          req_d            = 1'b0;
          place_valid_d    = 1'b1;
          place_d.block    = cur_block_q;
          place_d.col      = '0;
          place_d.rot      = '0;
          place_d.fallback = 1'b1;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_PRESENT: begin
        if (bus.place_ready) begin
          state_d       = ST_IDLE;
          place_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      req_q         <= 1'b0;
      cur_block_q   <= '0;
      place_q       <= '0;
      place_valid_q <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      req_q         <= req_d;
      cur_block_q   <= cur_block_d;
      place_q       <= place_d;
      place_valid_q <= place_valid_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign bus.blk_ready      = ~fifo_full;
  assign bus.busy           = (state_q != ST_IDLE) || (fifo_count != '0);
  assign bus.req_to_client  = req_q;
  assign bus.cur_block      = cur_block_q;
  assign bus.place_valid    = place_valid_q;
  assign bus.place_block    = place_q.block;
  assign bus.place_col      = place_q.col;
  assign bus.place_rotation = place_q.rot;
  assign bus.place_fallback = place_q.fallback;
  assign bus.timeout_cnt    = timeout_cnt_q;
endmodule
